// File: rtl/l1_pkg.sv
// Shared types and constants for the L1 data cache controller and its line storage.
package l1_pkg;

  localparam int L1_WORD_W   = 32;
  localparam int L1_IDX_BITS = 3;
  localparam int L1_TAG_W    = L1_WORD_W - L1_IDX_BITS;
  localparam int L2_HOLD_MIN = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    L2_REQ,
    RESP
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [L1_TAG_W-1:0] tag;
    logic [L1_WORD_W-1:0] data;
  } l1_line_t;

endpackage

// File: rtl/l1_array.sv
// Direct-mapped L1 line storage: asynchronous read, synchronous write, cleared on reset.
module l1_array
  import l1_pkg::*;
#(
  parameter int IDX_W = L1_IDX_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output l1_line_t         rd_line,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  l1_line_t         wr_line
);

  localparam int DEPTH = 2 ** IDX_W;

  l1_line_t lines [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        lines[i] <= '0;
      end
    end else if (wr_en) begin
      lines[wr_idx] <= wr_line;
    end
  end

  assign rd_line = lines[rd_idx];

endmodule

// File: rtl/l1_ctrl.sv
// Direct-mapped, write-through, write-allocate L1 controller in front of l2's raw
// capture/execute port; serves read hits locally and hides l2's phase from the CPU.
module l1_ctrl
  import l1_pkg::*;
#(
  parameter int WORD_SIZE = L1_WORD_W,
  parameter int L1_IDX_W  = L1_IDX_BITS,
  parameter int L2_HOLD   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [WORD_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic                 cpu_req_ready,
  output logic                 cpu_resp_valid,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  output logic                 cpu_l1_hit,
  output logic                 cpu_l2_miss,
  output logic                 l2_wr_en,
  output logic [WORD_SIZE-1:0] l2_addr,
  output logic [WORD_SIZE-1:0] l2_data,
  input  logic [WORD_SIZE-1:0] l2_data_out,
  input  logic                 l2_hit_or_miss,
  output state_e               state_dbg
);

  // Handshake: a request is taken on a rising edge where cpu_req and cpu_req_ready
  // are both 1; cpu_resp_valid is a single-cycle pulse with no back-pressure.

  // Holds shorter than the l2 minimum would miss its execute phase, so clamp.
  localparam int HOLD        = (L2_HOLD < L2_HOLD_MIN) ? L2_HOLD_MIN : L2_HOLD;
  localparam int CNT_W       = $clog2(HOLD);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(2);

  state_e               state;
  logic                 lat_we;
  logic [WORD_SIZE-1:0] lat_addr;
  logic [WORD_SIZE-1:0] lat_wdata;
  logic [CNT_W-1:0]     hold_cnt;
  logic                 l2_seen;
  logic [WORD_SIZE-1:0] l2_buf;

  logic [L1_IDX_W-1:0]  idx;
  l1_line_t             rd_line;
  logic                 line_hit;
  logic                 sample_hit;
  logic                 fill_hit;
  logic [WORD_SIZE-1:0] fill_data;
  logic                 hold_last;
  logic                 arr_wr_en;
  l1_line_t             arr_wr_line;

  assign idx       = lat_addr[L1_IDX_W-1:0];
  assign state_dbg = state;

  l1_array #(.IDX_W(L1_IDX_W)) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (idx),
    .rd_line (rd_line),
    .wr_en   (arr_wr_en),
    .wr_idx  (idx),
    .wr_line (arr_wr_line)
  );

  // l2 status before the third hold cycle may still belong to its previous phase.
  always_comb begin
    line_hit   = rd_line.valid && (rd_line.tag == lat_addr[WORD_SIZE-1:L1_IDX_W]);
    sample_hit = (hold_cnt >= CNT_SAMPLE) && l2_hit_or_miss;
    fill_hit   = l2_seen || sample_hit;
    fill_data  = l2_seen ? l2_buf : l2_data_out;
    hold_last  = (hold_cnt == CNT_LAST);
    arr_wr_en  = ((state == LOOKUP) && lat_we) ||
                 ((state == L2_REQ) && !lat_we && hold_last && fill_hit);
    arr_wr_line       = '0;
    arr_wr_line.valid = 1'b1;
    arr_wr_line.tag   = lat_addr[WORD_SIZE-1:L1_IDX_W];
    arr_wr_line.data  = lat_we ? lat_wdata : fill_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      lat_we         <= 1'b0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      hold_cnt       <= '0;
      l2_seen        <= 1'b0;
      l2_buf         <= '0;
      cpu_req_ready  <= 1'b1;
      cpu_resp_valid <= 1'b0;
      cpu_rdata      <= '0;
      cpu_l1_hit     <= 1'b0;
      cpu_l2_miss    <= 1'b0;
      l2_wr_en       <= 1'b0;
      l2_addr        <= '0;
      l2_data        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            lat_we        <= cpu_we;
            lat_addr      <= cpu_addr;
            lat_wdata     <= cpu_wdata;
            cpu_req_ready <= 1'b0;
            state         <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!lat_we && line_hit) begin
            cpu_rdata      <= rd_line.data;
            cpu_l1_hit     <= 1'b1;
            cpu_resp_valid <= 1'b1;
            state          <= RESP;
          end else begin
            cpu_l1_hit <= lat_we && line_hit;
            l2_wr_en   <= lat_we;
            l2_addr    <= lat_addr;
            l2_data    <= lat_we ? lat_wdata : '0;
            hold_cnt   <= '0;
            l2_seen    <= 1'b0;
            state      <= L2_REQ;
          end
        end
        L2_REQ: begin
          if (sample_hit && !l2_seen) begin
            l2_seen <= 1'b1;
            l2_buf  <= l2_data_out;
          end
          if (hold_last) begin
            l2_wr_en <= 1'b0;
            l2_addr  <= '0;
            l2_data  <= '0;
            if (!lat_we) begin
              cpu_rdata   <= fill_hit ? fill_data : '0;
              cpu_l2_miss <= !fill_hit;
            end
            cpu_resp_valid <= 1'b1;
            state          <= RESP;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          cpu_resp_valid <= 1'b0;
          cpu_rdata      <= '0;
          cpu_l1_hit     <= 1'b0;
          cpu_l2_miss    <= 1'b0;
          cpu_req_ready  <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_ctrl.sv
// Bench for l1_ctrl with a behavioural two-phase l2 model; table-driven vectors plus
// hand-written sequences for held requests and reset during an l2 transaction.
module tb_l1_ctrl;
  import l1_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_req_ready, cpu_resp_valid, cpu_l1_hit, cpu_l2_miss;
  logic [31:0] cpu_rdata;
  logic        l2_wr_en;
  logic [31:0] l2_addr, l2_data;
  logic [31:0] l2_data_out = '0;
  logic        l2_hit_or_miss = 1'b0;
  state_e      state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  l1_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_rdata      (cpu_rdata),
    .cpu_l1_hit     (cpu_l1_hit),
    .cpu_l2_miss    (cpu_l2_miss),
    .l2_wr_en       (l2_wr_en),
    .l2_addr        (l2_addr),
    .l2_data        (l2_data),
    .l2_data_out    (l2_data_out),
    .l2_hit_or_miss (l2_hit_or_miss),
    .state_dbg      (state_dbg)
  );

  // l2 model: free-running; every other edge captures the port and presents its result,
  // which then stays up for two cycles. Storage indexed by addr[7:0] with a full-address tag.
  logic         l2_phase = 1'b0;
  logic [255:0] l2_vld = '0;
  logic [31:0]  l2_tag [256];
  logic [31:0]  l2_mem [256];

  always @(posedge clk) begin
    l2_phase <= ~l2_phase;
    if (!l2_phase) begin
      if (l2_wr_en) begin
        l2_vld[l2_addr[7:0]] <= 1'b1;
        l2_tag[l2_addr[7:0]] <= l2_addr;
        l2_mem[l2_addr[7:0]] <= l2_data;
        l2_data_out          <= l2_data;
        l2_hit_or_miss       <= 1'b1;
      end else if (l2_vld[l2_addr[7:0]] && (l2_tag[l2_addr[7:0]] == l2_addr)) begin
        l2_data_out    <= l2_mem[l2_addr[7:0]];
        l2_hit_or_miss <= 1'b1;
      end else begin
        l2_data_out    <= '0;
        l2_hit_or_miss <= 1'b0;
      end
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    int          lat;
    logic [31:0] rdata;
    logic        l1_hit;
    logic        l2_miss;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_req(input vec_t v, input string name);
    int guard;
    int lat;
    int act;
    logic wr_seen;
    repeat (v.delay) begin
      @(posedge clk); #1;
    end
    guard = 0;
    while (!cpu_req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk($sformatf("%s ready", name), cpu_req_ready, 1);
    cpu_req   = 1'b1;
    cpu_we    = v.we;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    @(posedge clk); #1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    lat = 1;
    act = 0;
    wr_seen = 1'b0;
    while (!cpu_resp_valid && lat < 20) begin
      if (l2_wr_en || l2_addr != 0) act++;
      if (l2_wr_en) wr_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("%s latency", name), lat, v.lat);
    chk($sformatf("%s rdata", name), cpu_rdata, v.rdata);
    chk($sformatf("%s l1_hit", name), cpu_l1_hit, v.l1_hit);
    chk($sformatf("%s l2_miss", name), cpu_l2_miss, v.l2_miss);
    chk($sformatf("%s l2 hold cycles", name), act, (v.lat > 2) ? 4 : 0);
    chk($sformatf("%s l2 wr_en", name), wr_seen, v.we);
    @(posedge clk); #1;
    chk($sformatf("%s pulse", name), cpu_resp_valid, 0);
    chk($sformatf("%s rdata cleared", name), cpu_rdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] ready_seq, resp_seq, exp_ready, exp_resp;
    int resp_cnt;
    vec_t v;

    //           we    addr          wdata         dly lat rdata         l1  l2m
    vecs[0]  = '{1'b0, 32'h00000040, 32'h0,        0,  6,  32'h0,        0,  1};
    vecs[1]  = '{1'b1, 32'h00000040, 32'hDEADBEEF, 0,  6,  32'h0,        0,  0};
    vecs[2]  = '{1'b0, 32'h00000040, 32'h0,        0,  2,  32'hDEADBEEF, 1,  0};
    vecs[3]  = '{1'b1, 32'h00000048, 32'h11111111, 0,  6,  32'h0,        0,  0};
    vecs[4]  = '{1'b0, 32'h00000040, 32'h0,        0,  6,  32'hDEADBEEF, 0,  0};
    vecs[5]  = '{1'b0, 32'h00000040, 32'h0,        0,  2,  32'hDEADBEEF, 1,  0};
    vecs[6]  = '{1'b1, 32'h00000048, 32'h22222222, 1,  6,  32'h0,        0,  0};
    vecs[7]  = '{1'b0, 32'h00000040, 32'h0,        1,  6,  32'hDEADBEEF, 0,  0};
    vecs[8]  = '{1'b0, 32'h00000040, 32'h0,        0,  2,  32'hDEADBEEF, 1,  0};
    vecs[9]  = '{1'b1, 32'h00000041, 32'hA5A5A5A5, 0,  6,  32'h0,        0,  0};
    vecs[10] = '{1'b1, 32'h00000041, 32'h5A5A5A5A, 0,  6,  32'h0,        1,  0};
    vecs[11] = '{1'b0, 32'h00000041, 32'h0,        0,  2,  32'h5A5A5A5A, 1,  0};
    vecs[12] = '{1'b0, 32'h00000048, 32'h0,        0,  6,  32'h22222222, 0,  0};
    vecs[13] = '{1'b0, 32'h00000040, 32'h0,        0,  6,  32'hDEADBEEF, 0,  0};
    vecs[14] = '{1'b0, 32'h00000007, 32'h0,        0,  6,  32'h0,        0,  1};
    vecs[15] = '{1'b0, 32'hFFFFFFF8, 32'h0,        0,  6,  32'h0,        0,  1};
    vecs[16] = '{1'b0, 32'h00000040, 32'h0,        0,  2,  32'hDEADBEEF, 1,  0};

    rst       = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", cpu_req_ready, 1);
    chk("reset resp_valid", cpu_resp_valid, 0);
    chk("reset rdata", cpu_rdata, 0);
    chk("reset l1_hit", cpu_l1_hit, 0);
    chk("reset l2_miss", cpu_l2_miss, 0);
    chk("reset l2_wr_en", l2_wr_en, 0);
    chk("reset l2_addr", l2_addr, 0);
    chk("reset l2_data", l2_data, 0);
    chk("reset state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      do_req(vecs[i], $sformatf("vec%0d", i));
    end

    // Held request: 0x40 is an L1 hit, so one request per 3-cycle IDLE/LOOKUP/RESP loop.
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h40;
    for (int t = 0; t < 12; t++) begin
      ready_seq[t] = cpu_req_ready;
      resp_seq[t]  = cpu_resp_valid;
      exp_ready[t] = (t % 3 == 0);
      exp_resp[t]  = (t % 3 == 2);
      if (t < 11) begin
        @(posedge clk); #1;
      end
    end
    cpu_req  = 1'b0;
    cpu_addr = '0;
    chk("held req ready pattern", 32'(ready_seq), 32'(exp_ready));
    chk("held req resp pattern", 32'(resp_seq), 32'(exp_resp));
    @(posedge clk); #1;

    // Reset while an l2 read miss is in flight.
    cpu_req  = 1'b1;
    cpu_addr = 32'h52;
    @(posedge clk); #1;
    cpu_req  = 1'b0;
    cpu_addr = '0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("midrst l2_addr driven", l2_addr, 32'h52);
    rst = 1'b0;
    #1;
    chk("midrst ready", cpu_req_ready, 1);
    chk("midrst resp_valid", cpu_resp_valid, 0);
    chk("midrst l2_addr", l2_addr, 0);
    chk("midrst l2_wr_en", l2_wr_en, 0);
    chk("midrst state", 32'(state_dbg), 32'(IDLE));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    resp_cnt = 0;
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      if (cpu_resp_valid) resp_cnt++;
    end
    chk("midrst no response", resp_cnt, 0);
    chk("midrst ready after", cpu_req_ready, 1);

    v = '{1'b0, 32'h40, 32'h0, 0, 6, 32'hDEADBEEF, 1'b0, 1'b0};
    do_req(v, "post-reset read");
    v = '{1'b0, 32'h40, 32'h0, 0, 2, 32'hDEADBEEF, 1'b1, 1'b0};
    do_req(v, "post-reset reread");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
